alu_seq_ctrl: RTL and testbench
===============================

Name: alu_seq_ctrl

Overview:
Parametrised successor to the single-cycle ALU control decoder. It decodes ALUOp/Function into the 4-bit ALUCtrl code and also executes the selected operation. It adds iterative multi-cycle multiply/divide with HI/LO registers and a start/busy/done handshake. It sits in the EX stage of the multi-cycle datapath, between the main control unit and the register-file writeback.

Parameters:
WIDTH, 32, operand/result width in bits (>=4)
CTRL_W, 4, ALUCtrl code width

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  request; sampled only when busy=0
ALUOp  input  2  00 lw/sw, 01 beq, 1x R-type
Function  input  6  R-type funct field
a  input  WIDTH  operand rs
b  input  WIDTH  operand rt
ALUCtrl  output  CTRL_W  registered decoded control code
result  output  WIDTH  registered result
zero  output  1  result==0, registered with result
busy  output  1  high while multi-cycle op in progress
done  output  1  one-cycle pulse when result/HI/LO valid
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register
div_by_zero  output  1  sticky until next accepted start
illegal  output  1  undefined ALUOp/Function, valid with done

Behaviour:
- Clock is clk. Reset is synchronous and active-high on reset.
- Reset: ALUCtrl=0000, result=0, zero=1, busy=0, done=0, hi=0, lo=0, div_by_zero=0, illegal=0, FSM=IDLE. A reset asserted mid-operation aborts the operation; HI/LO are cleared and no done pulse is issued.
- Decode uses full 6-bit funct matching, not don't-care masking.
  - ALUOp 00 -> add (0010).
  - ALUOp 01 -> sub (0110).
  - R-type: 100000 add 0010; 100010 sub 0110; 100100 and 0000; 100101 or 0001; 100111 nor 1100; 101010 slt 0111 (signed compare, result 1/0); 010000 mfhi 1000; 010010 mflo 1001; 011001 multu 1010; 011011 divu 1011.
  - Any other code -> ALUCtrl=1111, illegal=1, result=0.
- FSM states: IDLE, MUL, DIV, FIN.
- IDLE + start, single-cycle op (add/sub/and/or/nor/slt/mfhi/mflo/illegal): ALUCtrl, result, zero and illegal are registered at the next edge. done=1 for that one cycle. Latency is 1. Remain in IDLE.
- IDLE + start, multu: capture a and b, go to MUL, busy=1. Shift-add runs one bit per cycle for WIDTH cycles, then FIN. In FIN: {hi,lo}=a*b (2*WIDTH bits), done=1, busy=0, return to IDLE. Latency is WIDTH+1. result holds its previous value.
- IDLE + start, divu, b!=0: go to DIV. Restoring division runs WIDTH cycles, then FIN. Result: lo=a/b, hi=a%b, done, latency WIDTH+1.
- divu with b==0: no iteration. The next edge gives done=1 and div_by_zero=1; hi/lo are unchanged. Latency is 1.
- start while busy=1 is ignored; the bench holds or re-issues it. busy stays high from the cycle after acceptance until the FIN cycle.
- Arithmetic wraps modulo 2^WIDTH; no overflow trap.
- mfhi/mflo issued in the same cycle a mult/div completes cannot happen, because start is ignored while busy. mfhi/mflo read HI/LO as they stand at acceptance.
- done is never high for two consecutive cycles from one start.

Optional Feature:
SIGNED_MULDIV_EN.
- Defined: also decodes 011000 mult (1101) and 011010 div (1110). Operands are converted to magnitude and the unsigned iterative core is reused. The result sign is corrected in FIN. The remainder takes the sign of the dividend; the quotient truncates toward zero. Latency is WIDTH+1. b==0 behaves as for divu.
- Undefined: 011000 and 011010 decode as illegal (1111, illegal=1, result=0, latency 1).

Test Plan:
- Reset held 2 cycles mid-multu -> all outputs at reset values, busy=0, no done pulse.
- R-type add a=7 b=5 -> next cycle ALUCtrl=0010, result=12, done=1. Then slt a=-1 b=1 -> result=1. Then nor a=0 b=0 -> result=0xFFFFFFFF.
- ALUOp=01, a=b=9 -> ALUCtrl=0110, result=0, zero=1. ALUOp=00, a=100 b=4 -> result=104.
- multu a=0xFFFFFFFF b=2 -> busy for 32 cycles, done at cycle 33, hi=1, lo=0xFFFFFFFE. A start pulse during busy is ignored. A following mfhi returns 1.
- divu a=17 b=5 -> lo=3, hi=2 after 33 cycles. divu b=0 -> done after 1 cycle, div_by_zero=1, hi/lo unchanged.
- Function=111111 -> ALUCtrl=1111, illegal=1. With SIGNED_MULDIV_EN: div a=-7 b=2 -> lo=-3, hi=-1. Without it: same code gives illegal=1.

Source files
------------

// File: rtl/alu_seq_ctrl.sv
// EX-stage ALU control decoder and executor with iterative multiply/divide and HI/LO registers.
// Define SIGNED_MULDIV_EN to add signed mult/div, which reuse the unsigned iterative core.
module alu_seq_ctrl #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        ALUOp,
  input  logic [5:0]        Function,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  output logic [CTRL_W-1:0] ALUCtrl,
  output logic [WIDTH-1:0]  result,
  output logic              zero,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  hi,
  output logic [WIDTH-1:0]  lo,
  output logic              div_by_zero,
  output logic              illegal
);

  localparam logic [3:0] C_AND   = 4'b0000;
  localparam logic [3:0] C_OR    = 4'b0001;
  localparam logic [3:0] C_ADD   = 4'b0010;
  localparam logic [3:0] C_SUB   = 4'b0110;
  localparam logic [3:0] C_SLT   = 4'b0111;
  localparam logic [3:0] C_MFHI  = 4'b1000;
  localparam logic [3:0] C_MFLO  = 4'b1001;
  localparam logic [3:0] C_MULTU = 4'b1010;
  localparam logic [3:0] C_DIVU  = 4'b1011;
  localparam logic [3:0] C_NOR   = 4'b1100;
  localparam logic [3:0] C_ILL   = 4'b1111;
`ifdef SIGNED_MULDIV_EN
  localparam logic [3:0] C_MULT  = 4'b1101;
  localparam logic [3:0] C_DIV   = 4'b1110;
`endif

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIN} state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_acc;    // product upper half / partial remainder
  logic [WIDTH-1:0]   r_shift;  // multiplier shifting out / dividend-to-quotient
  logic [WIDTH-1:0]   r_opnd;   // multiplicand / divisor
  logic               r_neg_q;
  logic               r_neg_r;

  logic [3:0]         w_ctrl;
  logic               w_illegal;
  logic [WIDTH-1:0]   w_alu;
  logic               w_is_mul;
  logic               w_is_div;
  logic               w_signed_op;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;

  // NOTE: every signal driven from always_comb gets a default first, so no
  // path through the case statements leaves it holding a value (no latch).
  always_comb begin
    w_ctrl = C_ILL;
    case (ALUOp)
      2'b00: w_ctrl = C_ADD;
      2'b01: w_ctrl = C_SUB;
      default: begin
        case (Function)
          6'b100000: w_ctrl = C_ADD;
          6'b100010: w_ctrl = C_SUB;
          6'b100100: w_ctrl = C_AND;
          6'b100101: w_ctrl = C_OR;
          6'b100111: w_ctrl = C_NOR;
          6'b101010: w_ctrl = C_SLT;
          6'b010000: w_ctrl = C_MFHI;
          6'b010010: w_ctrl = C_MFLO;
          6'b011001: w_ctrl = C_MULTU;
          6'b011011: w_ctrl = C_DIVU;
`ifdef SIGNED_MULDIV_EN
          6'b011000: w_ctrl = C_MULT;
          6'b011010: w_ctrl = C_DIV;
`endif
          default:   w_ctrl = C_ILL;
        endcase
      end
    endcase
  end

  assign w_illegal = (w_ctrl == C_ILL);

`ifdef SIGNED_MULDIV_EN
  assign w_is_mul    = (w_ctrl == C_MULTU) || (w_ctrl == C_MULT);
  assign w_is_div    = (w_ctrl == C_DIVU)  || (w_ctrl == C_DIV);
  assign w_signed_op = (w_ctrl == C_MULT)  || (w_ctrl == C_DIV);
`else
  assign w_is_mul    = (w_ctrl == C_MULTU);
  assign w_is_div    = (w_ctrl == C_DIVU);
  assign w_signed_op = 1'b0;
`endif

  // The most negative value negates to itself, which is the correct unsigned magnitude.
  assign w_mag_a = (w_signed_op && a[WIDTH-1]) ? -a : a;
  assign w_mag_b = (w_signed_op && b[WIDTH-1]) ? -b : b;

  always_comb begin
    w_alu = '0;
    case (w_ctrl)
      C_ADD:  w_alu = a + b;
      C_SUB:  w_alu = a - b;
      C_AND:  w_alu = a & b;
      C_OR:   w_alu = a | b;
      C_NOR:  w_alu = ~(a | b);
      C_SLT:  w_alu = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      C_MFHI: w_alu = hi;
      C_MFLO: w_alu = lo;
      default: w_alu = '0;
    endcase
  end

  // One shift-add multiply step: add multiplicand when the multiplier LSB is set, then shift right.
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH-1:0]   w_mul_hi;
  logic [WIDTH-1:0]   w_mul_lo;
  logic [2*WIDTH-1:0] w_prod_fix;

  assign w_mul_sum  = {1'b0, r_acc} + (r_shift[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
  assign w_mul_hi   = w_mul_sum[WIDTH:1];
  assign w_mul_lo   = {w_mul_sum[0], r_shift[WIDTH-1:1]};
  assign w_prod_fix = r_neg_q ? -{w_mul_hi, w_mul_lo} : {w_mul_hi, w_mul_lo};

  // One restoring-division step: shift in the next dividend bit, keep the difference if no borrow.
  logic [WIDTH:0]     w_div_sh;
  logic [WIDTH:0]     w_div_try;
  logic               w_div_ok;
  logic [WIDTH-1:0]   w_div_rem;
  logic [WIDTH-1:0]   w_div_quo;
  logic [WIDTH-1:0]   w_rem_fix;
  logic [WIDTH-1:0]   w_quo_fix;

  assign w_div_sh  = {r_acc, r_shift[WIDTH-1]};
  assign w_div_try = w_div_sh - {1'b0, r_opnd};
  assign w_div_ok  = ~w_div_try[WIDTH];
  assign w_div_rem = w_div_ok ? w_div_try[WIDTH-1:0] : w_div_sh[WIDTH-1:0];
  assign w_div_quo = {r_shift[WIDTH-2:0], w_div_ok};
  assign w_quo_fix = r_neg_q ? -w_div_quo : w_div_quo;
  assign w_rem_fix = r_neg_r ? -w_div_rem : w_div_rem;

  // NOTE: reset is sampled only at the clock edge, and the iteration registers
  // are cleared along with the outputs so an aborted operation leaves nothing behind.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_shift     <= '0;
      r_opnd      <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      ALUCtrl     <= '0;
      result      <= '0;
      zero        <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
      illegal     <= 1'b0;
    end else begin
      // NOTE: non-blocking default makes done a single-cycle pulse unless a branch below re-asserts it.
      done <= 1'b0;
      case (r_state)
        S_IDLE, S_FIN: begin
          r_state <= S_IDLE;
          if (start) begin
            ALUCtrl     <= CTRL_W'(w_ctrl);
            illegal     <= w_illegal;
            div_by_zero <= 1'b0;
            r_cnt       <= '0;
            r_neg_q     <= w_signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
            r_neg_r     <= w_signed_op & a[WIDTH-1];
            if (w_is_mul) begin
              r_acc   <= '0;
              r_shift <= w_mag_b;
              r_opnd  <= w_mag_a;
              busy    <= 1'b1;
              r_state <= S_MUL;
            end else if (w_is_div && (b == '0)) begin
              div_by_zero <= 1'b1;
              done        <= 1'b1;
            end else if (w_is_div) begin
              r_acc   <= '0;
              r_shift <= w_mag_a;
              r_opnd  <= w_mag_b;
              busy    <= 1'b1;
              r_state <= S_DIV;
            end else begin
              result <= w_alu;
              zero   <= (w_alu == '0);
              done   <= 1'b1;
            end
          end
        end

        S_MUL: begin
          r_acc   <= w_mul_hi;
          r_shift <= w_mul_lo;
          r_cnt   <= r_cnt + CNT_W'(1);
          if (r_cnt == LAST_STEP) begin
            hi      <= w_prod_fix[2*WIDTH-1:WIDTH];
            lo      <= w_prod_fix[WIDTH-1:0];
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= S_FIN;
          end
        end

        S_DIV: begin
          r_acc   <= w_div_rem;
          r_shift <= w_div_quo;
          r_cnt   <= r_cnt + CNT_W'(1);
          if (r_cnt == LAST_STEP) begin
            hi      <= w_rem_fix;
            lo      <= w_quo_fix;
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= S_FIN;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl: vector table, directed multi-cycle sequences,
// and randomized operations scored against a plain-arithmetic reference model.
module tb_alu_seq_ctrl;

  localparam int W = 32;

  logic          clk;
  logic          reset;
  logic          start;
  logic [1:0]    ALUOp;
  logic [5:0]    Function;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [3:0]    ALUCtrl;
  logic [W-1:0]  result;
  logic          zero;
  logic          busy;
  logic          done;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;
  logic          div_by_zero;
  logic          illegal;

  alu_seq_ctrl #(.WIDTH(W), .CTRL_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .ALUOp(ALUOp), .Function(Function),
    .a(a), .b(b), .ALUCtrl(ALUCtrl), .result(result), .zero(zero), .busy(busy),
    .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference architectural state.
  logic [W-1:0] m_hi, m_lo, m_result;
  logic         m_dbz;

  typedef struct {
    logic [1:0]   op;
    logic [5:0]   fn;
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic [3:0]   exp_ctrl;
    logic [W-1:0] exp_res;
    logic         exp_ill;
  } vec_t;

  vec_t vecs[$];
  logic [5:0] fns[13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] ref_ctrl(input logic [1:0] op, input logic [5:0] fn);
    if (op == 2'b00) return 4'b0010;
    if (op == 2'b01) return 4'b0110;
    case (fn)
      6'b100000: return 4'b0010;
      6'b100010: return 4'b0110;
      6'b100100: return 4'b0000;
      6'b100101: return 4'b0001;
      6'b100111: return 4'b1100;
      6'b101010: return 4'b0111;
      6'b010000: return 4'b1000;
      6'b010010: return 4'b1001;
      6'b011001: return 4'b1010;
      6'b011011: return 4'b1011;
`ifdef SIGNED_MULDIV_EN
      6'b011000: return 4'b1101;
      6'b011010: return 4'b1110;
`endif
      default:   return 4'b1111;
    endcase
  endfunction

  // Issue one request, update the model, wait (bounded) for done and compare everything.
  task automatic run_op(input string name, input logic [1:0] op, input logic [5:0] fn,
                        input logic [W-1:0] ia, input logic [W-1:0] ib, input int poke_at);
    logic [3:0]  ctrl;
    logic [63:0] prod;
    longint      sa, sb, sq, sr;
    int          exp_lat, lat, busy_cycles;
    bit          seen;
    ctrl    = ref_ctrl(op, fn);
    exp_lat = 1;
    m_dbz   = 1'b0;
    sa      = longint'($signed(ia));
    sb      = longint'($signed(ib));
    case (ctrl)
      4'b0010: m_result = ia + ib;
      4'b0110: m_result = ia - ib;
      4'b0000: m_result = ia & ib;
      4'b0001: m_result = ia | ib;
      4'b1100: m_result = ~(ia | ib);
      4'b0111: m_result = ($signed(ia) < $signed(ib)) ? 32'd1 : 32'd0;
      4'b1000: m_result = m_hi;
      4'b1001: m_result = m_lo;
      4'b1010: begin
        prod = {32'b0, ia} * {32'b0, ib};
        {m_hi, m_lo} = prod;
        exp_lat = W + 1;
      end
      4'b1101: begin
        prod = 64'(sa * sb);
        {m_hi, m_lo} = prod;
        exp_lat = W + 1;
      end
      4'b1011, 4'b1110: begin
        if (ib == '0) m_dbz = 1'b1;
        else begin
          if (ctrl == 4'b1011) begin
            m_lo = ia / ib;
            m_hi = ia % ib;
          end else begin
            sq = sa / sb;
            sr = sa % sb;
            m_lo = sq[W-1:0];
            m_hi = sr[W-1:0];
          end
          exp_lat = W + 1;
        end
      end
      default: m_result = '0;
    endcase

    @(negedge clk);
    ALUOp = op; Function = fn; a = ia; b = ib; start = 1'b1;
    lat = 0; busy_cycles = 0; seen = 0;
    while (!seen && lat < 3 * W) begin
      @(posedge clk); #1;
      start = 1'b0;
      lat++;
      if (lat == poke_at) begin
        start = 1'b1; ALUOp = 2'b10; Function = 6'b100000; a = ~ia; b = ib;
      end
      if (done) seen = 1;
      else if (busy) busy_cycles++;
    end
    check({name, ":done_seen"}, 64'(seen), 64'd1);
    check({name, ":latency"}, 64'(lat), 64'(exp_lat));
    check({name, ":busy_cycles"}, 64'(busy_cycles), 64'(exp_lat - 1));
    check({name, ":busy_at_done"}, 64'(busy), 64'd0);
    check({name, ":ALUCtrl"}, 64'(ALUCtrl), 64'(ctrl));
    check({name, ":illegal"}, 64'(illegal), 64'(ctrl == 4'b1111));
    check({name, ":result"}, 64'(result), 64'(m_result));
    check({name, ":zero"}, 64'(zero), 64'(m_result == '0));
    check({name, ":hi"}, 64'(hi), 64'(m_hi));
    check({name, ":lo"}, 64'(lo), 64'(m_lo));
    check({name, ":div_by_zero"}, 64'(div_by_zero), 64'(m_dbz));
    @(posedge clk); #1;
    check({name, ":done_one_cycle"}, 64'(done), 64'd0);
  endtask

  task automatic check_reset_state(input string name);
    check({name, ":ALUCtrl"}, 64'(ALUCtrl), 64'd0);
    check({name, ":result"}, 64'(result), 64'd0);
    check({name, ":zero"}, 64'(zero), 64'd1);
    check({name, ":busy"}, 64'(busy), 64'd0);
    check({name, ":done"}, 64'(done), 64'd0);
    check({name, ":hi"}, 64'(hi), 64'd0);
    check({name, ":lo"}, 64'(lo), 64'd0);
    check({name, ":div_by_zero"}, 64'(div_by_zero), 64'd0);
    check({name, ":illegal"}, 64'(illegal), 64'd0);
  endtask

  initial begin
    int done_pulses;
    reset = 1'b1; start = 1'b0; ALUOp = 2'b00; Function = 6'b0; a = '0; b = '0;
    m_hi = '0; m_lo = '0; m_result = '0; m_dbz = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("por");
    @(negedge clk);
    reset = 1'b0;

    // Reset held two cycles in the middle of a multu aborts it without a done pulse.
    @(negedge clk);
    ALUOp = 2'b10; Function = 6'b011001; a = 32'hFFFF_FFFF; b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("mid_multu:busy", 64'(busy), 64'd1);
    done_pulses = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done) done_pulses++;
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      if (done) done_pulses++;
    end
    check_reset_state("mid_reset");
    @(negedge clk);
    reset = 1'b0;
    repeat (2 * W) begin
      @(posedge clk); #1;
      if (done || busy) done_pulses++;
    end
    check("mid_reset:no_done_after_abort", 64'(done_pulses), 64'd0);

    // Single-cycle vector table.
    vecs.push_back('{2'b10, 6'b100000, 32'd7,         32'd5,         4'b0010, 32'd12,        1'b0});
    vecs.push_back('{2'b10, 6'b101010, 32'hFFFF_FFFF, 32'd1,         4'b0111, 32'd1,         1'b0});
    vecs.push_back('{2'b10, 6'b100111, 32'd0,         32'd0,         4'b1100, 32'hFFFF_FFFF, 1'b0});
    vecs.push_back('{2'b01, 6'b000000, 32'd9,         32'd9,         4'b0110, 32'd0,         1'b0});
    vecs.push_back('{2'b00, 6'b101010, 32'd100,       32'd4,         4'b0010, 32'd104,       1'b0});
    vecs.push_back('{2'b11, 6'b100010, 32'd0,         32'd1,         4'b0110, 32'hFFFF_FFFF, 1'b0});
    vecs.push_back('{2'b10, 6'b100100, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'b0000, 32'hF000_F000, 1'b0});
    vecs.push_back('{2'b10, 6'b100101, 32'hF0F0_F0F0, 32'h0F0F_0000, 4'b0001, 32'hFFFF_F0F0, 1'b0});
    vecs.push_back('{2'b10, 6'b100000, 32'hFFFF_FFFF, 32'd1,         4'b0010, 32'd0,         1'b0});
    vecs.push_back('{2'b10, 6'b101010, 32'd1,         32'hFFFF_FFFF, 4'b0111, 32'd0,         1'b0});
    vecs.push_back('{2'b10, 6'b101010, 32'h8000_0000, 32'h7FFF_FFFF, 4'b0111, 32'd1,         1'b0});
    vecs.push_back('{2'b10, 6'b111111, 32'd5,         32'd6,         4'b1111, 32'd0,         1'b1});
    vecs.push_back('{2'b10, 6'b010000, 32'd3,         32'd4,         4'b1000, 32'd0,         1'b0});
    vecs.push_back('{2'b10, 6'b100001, 32'd3,         32'd4,         4'b1111, 32'd0,         1'b1});
    for (int i = 0; i < vecs.size(); i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].fn, vecs[i].va, vecs[i].vb, 0);
      check($sformatf("vec%0d:table_ctrl", i), 64'(ALUCtrl), 64'(vecs[i].exp_ctrl));
      check($sformatf("vec%0d:table_result", i), 64'(result), 64'(vecs[i].exp_res));
      check($sformatf("vec%0d:table_illegal", i), 64'(illegal), 64'(vecs[i].exp_ill));
    end

    // multu with a re-issued start while busy, then read HI back.
    run_op("multu_max", 2'b10, 6'b011001, 32'hFFFF_FFFF, 32'd2, 5);
    check("multu_max:hi_const", 64'(hi), 64'd1);
    check("multu_max:lo_const", 64'(lo), 64'hFFFF_FFFE);
    run_op("mfhi_after_multu", 2'b10, 6'b010000, 32'd0, 32'd0, 0);
    check("mfhi_after_multu:result_const", 64'(result), 64'd1);

    run_op("divu_17_5", 2'b10, 6'b011011, 32'd17, 32'd5, 0);
    check("divu_17_5:lo_const", 64'(lo), 64'd3);
    check("divu_17_5:hi_const", 64'(hi), 64'd2);
    run_op("divu_by_zero", 2'b10, 6'b011011, 32'd17, 32'd0, 0);
    check("divu_by_zero:sticky_flag", 64'(div_by_zero), 64'd1);
    check("divu_by_zero:hi_kept", 64'(hi), 64'd2);
    check("divu_by_zero:lo_kept", 64'(lo), 64'd3);
    run_op("add_clears_dbz", 2'b10, 6'b100000, 32'd1, 32'd1, 0);
    check("add_clears_dbz:flag", 64'(div_by_zero), 64'd0);

`ifdef SIGNED_MULDIV_EN
    run_op("div_neg7_2", 2'b10, 6'b011010, 32'hFFFF_FFF9, 32'd2, 0);
    check("div_neg7_2:lo_const", 64'(lo), 64'hFFFF_FFFD);
    check("div_neg7_2:hi_const", 64'(hi), 64'hFFFF_FFFF);
    run_op("mult_neg3_5", 2'b10, 6'b011000, 32'hFFFF_FFFD, 32'd5, 0);
    check("mult_neg3_5:lo_const", 64'(lo), 64'hFFFF_FFF1);
    check("mult_neg3_5:hi_const", 64'(hi), 64'hFFFF_FFFF);
`else
    run_op("div_disabled", 2'b10, 6'b011010, 32'hFFFF_FFF9, 32'd2, 0);
    check("div_disabled:illegal_const", 64'(illegal), 64'd1);
    check("div_disabled:ctrl_const", 64'(ALUCtrl), 64'hF);
`endif

    // Randomized operations against the reference model.
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100111, 6'b101010, 6'b010000,
            6'b010010, 6'b011001, 6'b011011, 6'b011000, 6'b011010, 6'b000000};
    for (int i = 0; i < 80; i++) begin
      logic [1:0]   rop;
      logic [5:0]   rfn;
      logic [W-1:0] ra, rb;
      int           idx;
      rop = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3));
      idx = $urandom_range(0, 12);
      rfn = (idx == 12) ? 6'($urandom) : fns[idx];
      ra  = $urandom;
      case ($urandom_range(0, 9))
        0:       rb = '0;
        1, 2:    rb = 32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      run_op($sformatf("rand%0d", i), rop, rfn, ra, rb, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
